// File: rtl/writeback_arbiter_if.sv
// Write-port bundle: ALU and MEM result streams in,
// register bank write port and FIFO occupancy out.
interface writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] bus_rw;
  logic              reg_write;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rw, bus_rw, reg_write, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rw, bus_rw, reg_write, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and queued MEM results onto the single
// register bank write port, with starvation and full guards.
module writeback_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, DRAIN} state_t;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [SW-1:0]     starve;
  logic [SW-1:0]     starve_nxt;
  state_t            state;

  logic alu_fire;
  logic push;
  logic pop;

  assign bus.alu_ready  = (state == NORMAL);
  assign bus.mem_ready  = (count < CW'(DEPTH));
  assign bus.fifo_count = count;

  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign push     = bus.mem_valid && bus.mem_ready;
  // Pop uses the registered count, so a fresh push is never bypassed
  assign pop      = (count != '0) &&
                    ((state == DRAIN) || !alu_fire);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_comb begin
    starve_nxt = starve;
    if (pop || count_nxt == '0)
      starve_nxt = '0;
    else if (starve != SW'(STARVE_LIMIT))
      starve_nxt = starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= bus.mem_rd;
      data_q[tail] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      starve        <= '0;
      state         <= NORMAL;
      bus.rw        <= '0;
      bus.bus_rw    <= '0;
      bus.reg_write <= 1'b0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      count  <= count_nxt;
      starve <= starve_nxt;

      unique case (state)
        NORMAL: begin
          if (count_nxt == CW'(DEPTH) ||
              starve_nxt == SW'(STARVE_LIMIT))
            state <= DRAIN;
        end
        DRAIN:   state <= NORMAL;
        default: state <= NORMAL;
      endcase

      unique case (1'b1)
        alu_fire: begin
          bus.rw        <= bus.alu_rd;
          bus.bus_rw    <= bus.alu_data;
          bus.reg_write <= (bus.alu_rd != '0);
        end
        pop: begin
          bus.rw        <= rd_q[head];
          bus.bus_rw    <= data_q[head];
          bus.reg_write <= (rd_q[head] != '0);
        end
        default: bus.reg_write <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (state != DRAIN || count != '0)
        else $error("drain with empty fifo");
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter against
// a queue-based reference model of the arbitration rules.
module tb_writeback_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct {
    int               due;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  wr_t  exp_q[$];
  ent_t mq[$];
  int   starve = 0;
  bit   drain = 0;
  logic [ADDR_W-1:0] last_rw = '0;
  logic [DATA_W-1:0] last_data = '0;
  int   max_cnt;

  writeback_arbiter_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CW)
  ) bus ();

  writeback_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, longint act, longint want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h",
               name, cyc, act, want);
    end
  endtask

  // Monitor: compares registered write port against scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("rst_we", bus.reg_write, 0);
      chk("rst_rw", bus.rw, 0);
      chk("rst_data", bus.bus_rw, 0);
      chk("rst_cnt", bus.fifo_count, 0);
      last_rw = '0;
      last_data = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      wr_t w;
      w = exp_q.pop_front();
      chk("wr_we", bus.reg_write, (w.rd != 0));
      chk("wr_rw", bus.rw, w.rd);
      chk("wr_data", bus.bus_rw, w.data);
      last_rw = w.rd;
      last_data = w.data;
    end else begin
      chk("idle_we", bus.reg_write, 0);
      chk("hold_rw", bus.rw, last_rw);
      chk("hold_data", bus.bus_rw, last_data);
    end
  end

  // One cycle of stimulus plus the reference model step
  task automatic step(bit rst, bit av, int ard, int adat,
                      bit mv, int mrd, int mdat);
    bit   arq;
    bit   mrq;
    bit   popped;
    ent_t e;
    @(negedge clk);
    #2;
    reset         = rst;
    bus.alu_valid = av;
    bus.alu_rd    = ADDR_W'(ard);
    bus.alu_data  = DATA_W'(adat);
    bus.mem_valid = mv;
    bus.mem_rd    = ADDR_W'(mrd);
    bus.mem_data  = DATA_W'(mdat);
    #1;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      starve = 0;
      drain = 0;
      return;
    end
    arq = !drain;
    mrq = mq.size() < DEPTH;
    chk("alu_ready", bus.alu_ready, arq);
    chk("mem_ready", bus.mem_ready, mrq);
    chk("fifo_count", bus.fifo_count, mq.size());
    if (int'(bus.fifo_count) > max_cnt)
      max_cnt = int'(bus.fifo_count);
    popped = 0;
    if (av && arq) begin
      exp_q.push_back('{cyc + 1, ADDR_W'(ard), DATA_W'(adat)});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_q.push_back('{cyc + 1, e.rd, e.data});
      popped = 1;
    end
    if (mv && mrq)
      mq.push_back('{ADDR_W'(mrd), DATA_W'(mdat)});
    if (popped || mq.size() == 0)
      starve = 0;
    else if (starve < LIMIT)
      starve++;
    drain = !drain && (mq.size() == DEPTH || starve == LIMIT);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++)
      step(0, 1, i + 1, 32'h100 + i, 0, 0, 0);
    step(1, 1, 9, 32'h55, 1, 3, 32'h66);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 1, 0, 32'h77, 0, 0, 0);
    idle(2);

    step(0, 0, 0, 0, 1, 7, 32'h12);
    idle(3);

    for (int i = 0; i < 4; i++)
      step(0, 1, 10 + i, 32'hA0 + i, 1, 20 + i, 32'hB0 + i);
    for (int i = 0; i < 10; i++)
      step(0, 1, 14 + i % 8, 32'hC0 + i, 0, 0, 0);
    idle(6);

    step(0, 1, 1, 32'hE0, 1, 25, 32'hF00D);
    for (int i = 0; i < 11; i++)
      step(0, 1, 2 + i, 32'hE1 + i, 0, 0, 0);
    idle(3);

    max_cnt = 0;
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 0, 1, 1 + i, 32'h900 + i);
    idle(4);
    chk("stream_max_cnt", max_cnt <= 2, 1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31),
           $urandom, $urandom_range(0, 1) != 0,
           $urandom_range(0, 31), $urandom);
    idle(12);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
